// File: rtl/ram_burst_reader_pkg.sv
// Shared widths, depth and controller state encoding for the RAM burst reader.
package ram_burst_reader_pkg;

    localparam int RAM_AW    = 6;
    localparam int RAM_DW    = 8;
    localparam int RAM_DEPTH = 64;
    localparam int LEN_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Any length with the MSB set means a full-RAM burst.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
        return l[LEN_W-1] ? LEN_W'(RAM_DEPTH) : l;
    endfunction

endpackage

// File: rtl/ram_burst_reader_sync_fifo2.sv
// Two-entry fall-through FIFO: an empty FIFO presents the incoming word on the
// same cycle, so a 1-cycle RAM read can stream out with no extra latency.
module sync_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [1:0][DW-1:0] mem_q, mem_d;
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               empty, push, pop, store, deq;

    assign empty     = (count_q == 2'd0);
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : mem_q[rd_ptr_q];
    assign in_ready  = (count_q != 2'd2) || out_ready;
    assign count     = count_q;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    // A word that arrives into an empty FIFO and leaves at once is never stored.
    assign store = push && !(empty && pop);
    assign deq   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (store) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, store} - {1'b0, deq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of consecutive (wrapping) RAM words and streams them out with
// valid/ready flow control, never holding more than two words in flight.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RAM_AW-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    input  logic [RAM_DW-1:0] ram_data,
    output logic [RAM_DW-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        fifo_count;
    logic              fifo_in_ready;
    logic              xfer, issue;
    logic [2:0]        occ;

    sync_fifo2 #(.DW(RAM_DW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_ready  (fifo_in_ready),
        .in_data   (ram_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (fifo_count)
    );

    assign xfer = out_valid && out_ready;
    assign occ  = {1'b0, fifo_count} + {2'b0, inflight_q};
    // Buffered plus in-flight words, net of the beat leaving now, must stay below 2.
    assign issue = (state_q == ST_READ) && fifo_in_ready && (occ < (3'd2 + {2'b0, xfer}));

    assign ram_addr = addr_q;
    assign ram_we   = 1'b0;
    assign out_last = out_valid && (beat_cnt_q == len_q - LEN_W'(1));
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        inflight_d = issue;

        if (xfer) begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
        if (issue) begin
            addr_d   = addr_q + RAM_AW'(1);
            rd_cnt_d = rd_cnt_q + LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = sat_len(len);
                    rd_cnt_d   = '0;
                    beat_cnt_d = '0;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                        addr_d  = base_addr;
                    end
                end
            end
            ST_READ: begin
                if (issue && (rd_cnt_q == len_q - LEN_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench: a queue of expected beats built from the RAM contents is
// compared against every transferred beat, with literal timing pins per test.
module tb_ram_burst_reader;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic [5:0] base_addr;
    logic [6:0] len;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_data;
    logic [7:0] out_data;
    logic       out_valid, out_last, busy, done;

    ram_burst_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_data  (ram_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [64];
    always @(posedge clk) ram_data <= mem[ram_addr];

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur;
    int    checks = 0;
    int    passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Expected stream: words base, base+1, ... mod 64, last flag on the final one.
    task automatic push_burst(input int b, input int l);
        int    n;
        beat_t e;
        n = (l > 64) ? 64 : l;
        for (int i = 0; i < n; i++) begin
            e.d = mem[(b + i) % 64];
            e.l = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    bit         stall_prev = 1'b0;
    logic [7:0] d_prev;
    logic       l_prev;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            chk("ram_we", ram_we, 0);
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, d_prev);
                chk("stall_last", out_last, l_prev);
            end
            if (out_valid && out_ready) begin
                chk("beat_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("beat_data", out_data, cur.d);
                    chk("beat_last", out_last, cur.l);
                end
            end
            stall_prev = out_valid && !out_ready;
            d_prev     = out_data;
            l_prev     = out_last;
        end
    end

    task automatic start_burst(input int b, input int l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 6'(b); len = 7'(l);
        push_burst(b, l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns number of negedges seen before done; toggle varies out_ready.
    task automatic wait_done(input string nm, input bit toggle, output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                cyc  = n;
                break;
            end
            @(posedge clk); #1;
            if (toggle) out_ready = ((n % 3) != 1);
        end
        out_ready = 1'b1;
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_done_once"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int waited;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", ram_addr, 0);

        // Basic: base 5 len 4, data on T+2..T+5, done at T+6.
        start_burst(5, 4);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("b1_valid", out_valid, (k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) chk("b1_data", out_data, 5 + k - 2);
            chk("b1_last", out_last, (k == 5));
            chk("b1_done", done, (k == 6));
            chk("b1_busy", busy, 1);
        end
        @(negedge clk);
        chk("b1_idle", busy, 0);
        chk("b1_drained", exp_q.size(), 0);

        // Wrap: addresses 62,63,0,1.
        start_burst(62, 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("wrap_addr", ram_addr, (61 + k) % 64);
        end
        wait_done("wrap", 1'b0, cyc);

        // Backpressure: first beat held 5 cycles, then full rate.
        out_ready = 1'b0;
        start_burst(0, 8);
        @(negedge clk);
        chk("bp_t1_valid", out_valid, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("bp", 1'b0, cyc);
        chk("bp_done_cycle", cyc, 8);

        // len 0: done next cycle, no beats, address untouched (left at 8).
        start_burst(7, 0);
        @(negedge clk);
        chk("z_done", done, 1);
        chk("z_busy", busy, 1);
        chk("z_valid", out_valid, 0);
        chk("z_addr", ram_addr, 8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("z_valid_after", out_valid, 0);
            chk("z_done_after", done, 0);
            chk("z_addr_after", ram_addr, 8);
        end

        // Reset mid-burst after two beats.
        start_burst(30, 10);
        waited = 0;
        while (exp_q.size() > 8 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid_reached", exp_q.size(), 8);
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rmid_valid", out_valid, 0);
        chk("rmid_last", out_last, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_done", done, 0);
        chk("rmid_addr", ram_addr, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rmid_no_done", done, 0);
            chk("rmid_no_valid", out_valid, 0);
        end
        start_burst(20, 2);
        wait_done("after_rst", 1'b0, cyc);

        // Start during a burst is ignored; len 6 finishes at T+8.
        start_burst(10, 6);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 6'd40; len = 7'd3;
        @(posedge clk); #1 start = 1'b0;
        wait_done("ignore", 1'b0, cyc);
        chk("ignore_done_cycle", cyc, 5);

        // Oversized length saturates to 64, with ragged ready.
        start_burst(0, 100);
        wait_done("sat", 1'b1, cyc);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 base_addr  input  6  first RAM address of the burst; captured with start.
REQ-005 len  input  7  beat count, 0..64; captured with start.
REQ-006 ram_addr  output  6  address to the RAM port (64x8, registered read, 1-cycle latency).
REQ-007 ram_we  output  1  RAM write enable; constant 0.
REQ-008 ram_data  input  8  RAM read data, valid the cycle after ram_addr is presented.
REQ-009 out_data  output  8  stream data.
REQ-010 out_valid  output  1  stream valid.
REQ-011 out_ready  input  1  stream ready; a beat transfers when out_valid and out_ready are both high.
REQ-012 out_last  output  1  high with the final beat of a burst.
REQ-013 busy  output  1  high from the cycle after an accepted start until done.
REQ-014 done  output  1  one-cycle pulse when the burst completes.

Function
REQ-015 States: IDLE, READ, DRAIN, DONE; encoding is free.
- IDLE -> READ on start with len!=0; IDLE -> DONE on start with len==0.
- READ -> DRAIN after the len-th read is issued.
- DRAIN -> DONE on the transfer of the out_last beat.
- DONE -> IDLE unconditionally.
REQ-016 Reads are issued only in READ; address sequence is base_addr, base_addr+1, ... modulo 64 (63 wraps to 0).
REQ-017 A read is issued in a cycle only if buffered beats + reads in flight - (beat transferring this cycle) < 2.
REQ-018 Returning read data is written into a 2-entry FIFO. out_data/out_valid come from the FIFO head. The FIFO never overflows, and data is never dropped or duplicated.
REQ-019 Sustained throughput is 1 beat/cycle with out_ready held high. The first out_valid appears 2 cycles after the start cycle (start at T: first read at T+1, out_valid at T+2).
REQ-020 out_data and out_last are held stable while out_valid is high and out_ready is low.
REQ-021 out_last is high on exactly beat len of the burst and on no other beat.
REQ-022 done is high only in DONE, for exactly one cycle. busy is high in READ, DRAIN and DONE.
REQ-023 start is ignored when not in IDLE, and no burst parameters change in that case.
REQ-024 len==0: no reads are issued, no beats are produced, and done pulses the cycle after start.
REQ-025 len>64 is illegal and is treated as 64 (MSB saturates).

Reset
REQ-026 rst forces IDLE, empties the FIFO and cancels any in-flight read. On the cycle after rst: out_valid=0, out_last=0, busy=0, done=0, ram_addr=0, ram_we=0.
REQ-027 rst mid-burst aborts without done. A read returning after reset is discarded.
REQ-028 rst takes priority over start in the same cycle.

Structure
REQ-029 Shared package holds RAM_AW=6, RAM_DW=8, RAM_DEPTH=64, LEN_W=7 and the state enumeration.
REQ-030 One sub-module, sync_fifo2 (2-entry, valid/ready, synchronous reset), provides the output buffer. The FSM, address counter and beat counter stay in ram_burst_reader.

Verification
REQ-031 RAM preloaded ram[i]=i; start base=5 len=4, ready=1 -> data 5,6,7,8 on cycles T+2..T+5, last on 8, done at T+6.
REQ-032 Wrap: base=62 len=4 -> reads 62,63,0,1; data 62,63,0,1.
REQ-033 Backpressure: base=0 len=8, ready low for 5 cycles after the first beat -> data stays 0 while stalled, then 0..7 complete. No more than 2 reads are outstanding beyond accepted beats.
REQ-034 len=0 -> out_valid never asserts; done pulses at T+1; ram_addr does not change.
REQ-035 rst asserted after 2 beats of a len=10 burst -> next cycle idle outputs, no done. A following burst base=20 len=2 returns 20,21 only.
REQ-036 start pulsed during a burst (base=40) -> ignored; the current burst's data and count are unchanged.
